// File: rtl/fp_narrow_pack_pkg.sv
// Shared types for the FP narrowing packer: status flags, packed FIFO entry
// and the pairing state.
package fp_narrow_pack_pkg;

    localparam int PACK_ELEM_WIDTH = 32;
    localparam int PACK_DATA_WIDTH = 64;
    localparam int PACK_FIFO_DEPTH = 4;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fp_status_flags;

    typedef struct packed {
        logic [PACK_DATA_WIDTH-1:0] data;
        logic [1:0]                 mask;
        fp_status_flags             status;
    } pack_entry_t;

    typedef enum logic {
        LO_EMPTY = 1'b0,
        LO_HELD  = 1'b1
    } pack_state_t;

endpackage

// File: rtl/fp_pack_fifo.sv
// Synchronous FIFO of packed words; the head entry is visible combinationally
// and reads as zero when the FIFO is empty.
module fp_pack_fifo
    import fp_narrow_pack_pkg::*;
#(
    parameter int DEPTH = PACK_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  pack_entry_t              wdata,
    input  logic                     pop,
    output pack_entry_t              head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    pack_entry_t   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == (AW+1)'(0));
    assign count     = count_r;
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign head      = empty ? pack_entry_t'(0) : mem_r[rd_ptr_r];

    // Storage, pointers and occupancy; clr empties the queue without touching storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (clr) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fp_narrow_pack.sv
// Pairs consecutive 32-bit narrowed results into 64-bit words with merged
// status flags and queues them for vector register writeback.
module fp_narrow_pack
    import fp_narrow_pack_pkg::*;
#(
    parameter int ELEM_WIDTH = PACK_ELEM_WIDTH,
    parameter int DATA_WIDTH = PACK_DATA_WIDTH,
    parameter int FIFO_DEPTH = PACK_FIFO_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_result_i,
    input  fp_status_flags        in_status_i,
    input  logic                  in_last_i,
    output logic                  in_ready_o,
    input  logic                  abort_i,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [1:0]            out_mask_o,
    output fp_status_flags        out_status_o,
    input  logic                  out_ready_i
);

    pack_state_t                 state_r;
    pack_state_t                 state_next_s;
    logic [ELEM_WIDTH-1:0]       hold_data_r;
    logic [ELEM_WIDTH-1:0]       hold_data_next_s;
    fp_status_flags              hold_status_r;
    fp_status_flags              hold_status_next_s;
    logic [ELEM_WIDTH-1:0]       elem_s;
    logic                        acc_s;
    logic                        push_s;
    logic                        pop_s;
    pack_entry_t                 push_entry_s;
    pack_entry_t                 head_s;
    logic                        fifo_full_s;
    logic                        fifo_empty_s;
    logic [$clog2(FIFO_DEPTH):0] fifo_count_s;
    logic                        unused_s;

    assign elem_s      = in_result_i[ELEM_WIDTH-1:0];
    assign unused_s    = ^{in_result_i[DATA_WIDTH-1:ELEM_WIDTH], fifo_count_s};
    // Held low throughout reset; otherwise purely the registered full flag.
    assign in_ready_o  = ~fifo_full_s & ~rst_i;
    assign acc_s       = in_valid_i & in_ready_o;
    assign out_valid_o = ~fifo_empty_s;
    assign pop_s       = out_valid_o & out_ready_i & ~abort_i;

    assign out_data_o   = head_s.data;
    assign out_mask_o   = head_s.mask;
    assign out_status_o = head_s.status;

    // Pairing FSM: decide what to hold and what completed word to push.
    always_comb begin
        state_next_s       = state_r;
        hold_data_next_s   = hold_data_r;
        hold_status_next_s = hold_status_r;
        push_s             = 1'b0;
        push_entry_s       = '0;
        if (abort_i) begin
            state_next_s       = LO_EMPTY;
            hold_data_next_s   = '0;
            hold_status_next_s = '0;
        end else if (acc_s) begin
            case (state_r)
                LO_EMPTY: begin
                    if (in_last_i) begin
                        push_s              = 1'b1;
                        push_entry_s.data   = {{(DATA_WIDTH-ELEM_WIDTH){1'b0}}, elem_s};
                        push_entry_s.mask   = 2'b01;
                        push_entry_s.status = in_status_i;
                    end else begin
                        hold_data_next_s   = elem_s;
                        hold_status_next_s = in_status_i;
                        state_next_s       = LO_HELD;
                    end
                end
                LO_HELD: begin
                    push_s              = 1'b1;
                    push_entry_s.data   = {elem_s, hold_data_r};
                    push_entry_s.mask   = 2'b11;
                    push_entry_s.status = hold_status_r | in_status_i;
                    hold_data_next_s    = '0;
                    hold_status_next_s  = '0;
                    state_next_s        = LO_EMPTY;
                end
                default: begin
                    state_next_s = LO_EMPTY;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Pairing state and holding register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r       <= LO_EMPTY;
            hold_data_r   <= '0;
            hold_status_r <= '0;
        end else begin
            state_r       <= state_next_s;
            hold_data_r   <= hold_data_next_s;
            hold_status_r <= hold_status_next_s;
        end
    end

    fp_pack_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (abort_i),
        .push  (push_s),
        .wdata (push_entry_s),
        .pop   (pop_s),
        .head  (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

endmodule

// File: tb/tb_fp_narrow_pack.sv
// Directed bench for fp_narrow_pack: per-cycle vector table plus hand-written
// backpressure, abort and asynchronous reset sequences.
module tb_fp_narrow_pack;
    import fp_narrow_pack_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_result;
    logic [4:0]  in_status;
    logic        in_last;
    logic        in_ready;
    logic        abort;
    logic        out_valid;
    logic [63:0] out_data;
    logic [1:0]  out_mask;
    logic [4:0]  out_status;
    logic        out_ready;

    int checks   = 0;
    int failures = 0;

    fp_narrow_pack dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_valid_i   (in_valid),
        .in_result_i  (in_result),
        .in_status_i  (in_status),
        .in_last_i    (in_last),
        .in_ready_o   (in_ready),
        .abort_i      (abort),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data),
        .out_mask_o   (out_mask),
        .out_status_o (out_status),
        .out_ready_i  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] elem;
        logic [4:0]  st;
        logic        last;
        logic        ordy;
        logic        exp_valid;
        logic [63:0] exp_data;
        logic [1:0]  exp_mask;
        logic [4:0]  exp_st;
    } vec_t;

    vec_t vecs [24];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [63:0] d,
                           input logic [1:0] m, input logic [4:0] s, input logic r);
        chk({tag, ".valid"},  {63'd0, out_valid}, {63'd0, v});
        chk({tag, ".data"},   out_data, d);
        chk({tag, ".mask"},   {62'd0, out_mask}, {62'd0, m});
        chk({tag, ".status"}, {59'd0, out_status}, {59'd0, s});
        chk({tag, ".ready"},  {63'd0, in_ready}, {63'd0, r});
    endtask

    task automatic drive(input logic v, input logic [31:0] e, input logic [4:0] s,
                         input logic l, input logic r);
        in_valid  = v;
        in_result = {32'hDEADBEEF, e};
        in_status = s;
        in_last   = l;
        out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] bp_exp [4];

    initial begin
        // Pair, odd flush, status merge, last-on-high, long hold, stalled head.
        vecs[0]  = '{1'b1, 32'h3F800000, 5'h00, 1'b0, 1'b1, 1'b0, 64'h0, 2'b00, 5'h00};
        vecs[1]  = '{1'b1, 32'h40000000, 5'h00, 1'b0, 1'b1, 1'b1, 64'h40000000_3F800000, 2'b11, 5'h00};
        vecs[2]  = '{1'b1, 32'h3F800000, 5'h00, 1'b0, 1'b1, 1'b0, 64'h0, 2'b00, 5'h00};
        vecs[3]  = '{1'b1, 32'h40000000, 5'h00, 1'b0, 1'b1, 1'b1, 64'h40000000_3F800000, 2'b11, 5'h00};
        vecs[4]  = '{1'b1, 32'h40400000, 5'h00, 1'b1, 1'b1, 1'b1, 64'h00000000_40400000, 2'b01, 5'h00};
        vecs[5]  = '{1'b1, 32'h3F800000, 5'h01, 1'b0, 1'b1, 1'b0, 64'h0, 2'b00, 5'h00};
        vecs[6]  = '{1'b1, 32'h40000000, 5'h04, 1'b0, 1'b1, 1'b1, 64'h40000000_3F800000, 2'b11, 5'h05};
        vecs[7]  = '{1'b1, 32'h3F800000, 5'h00, 1'b0, 1'b1, 1'b0, 64'h0, 2'b00, 5'h00};
        vecs[8]  = '{1'b1, 32'h40400000, 5'h00, 1'b0, 1'b1, 1'b1, 64'h40400000_3F800000, 2'b11, 5'h00};
        vecs[9]  = '{1'b0, 32'h00000000, 5'h00, 1'b0, 1'b1, 1'b0, 64'h0, 2'b00, 5'h00};
        vecs[10] = '{1'b1, 32'h41000000, 5'h00, 1'b0, 1'b1, 1'b0, 64'h0, 2'b00, 5'h00};
        vecs[11] = '{1'b1, 32'h41200000, 5'h02, 1'b1, 1'b1, 1'b1, 64'h41200000_41000000, 2'b11, 5'h02};
        vecs[12] = '{1'b0, 32'h00000000, 5'h00, 1'b0, 1'b1, 1'b0, 64'h0, 2'b00, 5'h00};
        vecs[13] = '{1'b1, 32'h42000000, 5'h08, 1'b1, 1'b1, 1'b1, 64'h00000000_42000000, 2'b01, 5'h08};
        vecs[14] = '{1'b0, 32'h00000000, 5'h00, 1'b0, 1'b1, 1'b0, 64'h0, 2'b00, 5'h00};
        vecs[15] = '{1'b1, 32'h11111111, 5'h00, 1'b0, 1'b1, 1'b0, 64'h0, 2'b00, 5'h00};
        vecs[16] = '{1'b0, 32'h00000000, 5'h00, 1'b0, 1'b1, 1'b0, 64'h0, 2'b00, 5'h00};
        vecs[17] = '{1'b0, 32'h00000000, 5'h00, 1'b0, 1'b1, 1'b0, 64'h0, 2'b00, 5'h00};
        vecs[18] = '{1'b1, 32'h22222222, 5'h10, 1'b0, 1'b1, 1'b1, 64'h22222222_11111111, 2'b11, 5'h10};
        vecs[19] = '{1'b0, 32'h00000000, 5'h00, 1'b0, 1'b1, 1'b0, 64'h0, 2'b00, 5'h00};
        vecs[20] = '{1'b1, 32'hAAAA0001, 5'h00, 1'b0, 1'b1, 1'b0, 64'h0, 2'b00, 5'h00};
        vecs[21] = '{1'b1, 32'hAAAA0002, 5'h04, 1'b0, 1'b0, 1'b1, 64'hAAAA0002_AAAA0001, 2'b11, 5'h04};
        vecs[22] = '{1'b0, 32'h00000000, 5'h00, 1'b0, 1'b0, 1'b1, 64'hAAAA0002_AAAA0001, 2'b11, 5'h04};
        vecs[23] = '{1'b0, 32'h00000000, 5'h00, 1'b0, 1'b1, 1'b0, 64'h0, 2'b00, 5'h00};

        rst   = 1'b1;
        abort = 1'b0;
        drive(1'b0, 32'h0, 5'h00, 1'b0, 1'b1);
        tick();
        chk_out("reset", 1'b0, 64'h0, 2'b00, 5'h00, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_reset.ready", {63'd0, in_ready}, 64'd1);

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].valid, vecs[i].elem, vecs[i].st, vecs[i].last, vecs[i].ordy);
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                    vecs[i].exp_mask, vecs[i].exp_st, 1'b1);
        end

        // Backpressure: eight elements fill all four entries.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'hB0000000 + 32'(i), 5'h00, 1'b0, 1'b0);
            tick();
            chk($sformatf("bp_fill%0d.ready", i), {63'd0, in_ready},
                {63'd0, ((i + 1) / 2) < 4});
        end
        for (int k = 0; k < 4; k++) begin
            bp_exp[k] = {32'hB0000000 + 32'(2 * k + 1), 32'hB0000000 + 32'(2 * k)};
        end
        drive(1'b1, 32'hEEEE0008, 5'h00, 1'b0, 1'b0);
        tick();
        chk("bp_full.ready", {63'd0, in_ready}, 64'd0);
        chk("bp_full.head", out_data, bp_exp[0]);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp_drain%0d.valid", k), {63'd0, out_valid}, 64'd1);
            chk($sformatf("bp_drain%0d.data", k), out_data, bp_exp[k]);
            tick();
            if (k == 0) begin
                chk("bp_ready_return", {63'd0, in_ready}, 64'd1);
                in_valid = 1'b0;
            end
        end
        chk("bp_drained.valid", {63'd0, out_valid}, 64'd0);
        drive(1'b1, 32'hC0000001, 5'h00, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'hC0000002, 5'h00, 1'b0, 1'b1);
        tick();
        chk_out("bp_after", 1'b1, 64'hC0000002_C0000001, 2'b11, 5'h00, 1'b1);
        drive(1'b0, 32'h0, 5'h00, 1'b0, 1'b1);
        tick();

        // Abort with one element held and two words queued.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'hD0000000 + 32'(i), 5'h01, 1'b0, 1'b0);
            tick();
        end
        chk("abort_pre.valid", {63'd0, out_valid}, 64'd1);
        drive(1'b1, 32'hDEAD0000, 5'h02, 1'b0, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_out("abort", 1'b0, 64'h0, 2'b00, 5'h00, 1'b1);
        drive(1'b1, 32'hE0000001, 5'h00, 1'b0, 1'b1);
        tick();
        chk("abort_y1.valid", {63'd0, out_valid}, 64'd0);
        drive(1'b1, 32'hE0000002, 5'h00, 1'b0, 1'b1);
        tick();
        chk_out("abort_fresh", 1'b1, 64'hE0000002_E0000001, 2'b11, 5'h00, 1'b1);
        drive(1'b0, 32'h0, 5'h00, 1'b0, 1'b1);
        tick();

        // Asynchronous reset mid-cycle with a word queued and an element held.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hF0000000 + 32'(i), 5'h08, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 5'h00, 1'b0, 1'b0);
        chk("rst_pre.valid", {63'd0, out_valid}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_out("async_rst", 1'b0, 64'h0, 2'b00, 5'h00, 1'b0);
        tick();
        chk("rst_held.ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_release.ready", {63'd0, in_ready}, 64'd1);
        drive(1'b1, 32'h3F800000, 5'h00, 1'b0, 1'b1);
        tick();
        chk("rst_pair1.valid", {63'd0, out_valid}, 64'd0);
        drive(1'b1, 32'h40000000, 5'h00, 1'b0, 1'b1);
        tick();
        chk_out("rst_pair", 1'b1, 64'h40000000_3F800000, 2'b11, 5'h00, 1'b1);
        drive(1'b0, 32'h0, 5'h00, 1'b0, 1'b1);
        tick();
        chk("final.valid", {63'd0, out_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
